// File: rtl/upd_host_master.sv
// Host-side bus initiator for the uPD77C25 host port: turns single-byte requests into
// timed nCS/nRD/nWR/A0 cycles, with optional SR.RQM polling ahead of the data access.
module upd_host_master #(
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned STROBE_CYC = 16,
    parameter int unsigned HOLD_CYC   = 4,
    parameter int unsigned POLL_LIMIT = 4095
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_WR,
    input  logic       REQ_A0,
    input  logic [7:0] REQ_DATA,
    input  logic       REQ_WAIT_RQM,
    output logic       RSP_VALID,
    output logic [7:0] RSP_DATA,
    output logic       RSP_TIMEOUT,
    output logic       BUSY,
    output logic [7:0] BUS_DO,
    input  logic [7:0] BUS_DI,
    output logic       BUS_A0,
    output logic       BUS_nCS,
    output logic       BUS_nRD,
    output logic       BUS_nWR
);

    typedef enum logic [2:0] {
        IDLE, P_SETUP, P_STROBE, P_HOLD, D_SETUP, D_STROBE, D_HOLD, RESP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] poll_q, poll_d;
    logic        gap_q, gap_d;
    logic        wr_q, wr_d;
    logic        a0_q, a0_d;
    logic [7:0]  data_q, data_d;
    logic        rqm_q, rqm_d;
    logic        tout_q, tout_d;

    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_tout_q, rsp_tout_d;
    logic [7:0]  bus_do_q, bus_do_d;
    logic        bus_a0_q, bus_a0_d;
    logic        bus_ncs_q, bus_ncs_d;
    logic        bus_nrd_q, bus_nrd_d;
    logic        bus_nwr_q, bus_nwr_d;

    logic [7:0]  dur_last;
    logic        last;
    logic        accept;
    logic        in_poll, in_data;

    // Handshake: a request transfers on a rising CLK where REQ_VALID and REQ_READY are both
    // high; REQ_READY is only high in IDLE and drops on the edge that accepts.
    assign accept = REQ_VALID && ready_q;

    always_comb begin
        case (state_q)
            P_SETUP, D_SETUP:   dur_last = 8'(SETUP_CYC - 1);
            P_STROBE, D_STROBE: dur_last = 8'(STROBE_CYC - 1);
            default:            dur_last = 8'(HOLD_CYC - 1);
        endcase
    end

    assign last = (cnt_q == dur_last);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 8'd1;
        poll_d     = poll_q;
        gap_d      = 1'b0;
        wr_d       = wr_q;
        a0_d       = a0_q;
        data_d     = data_q;
        rqm_d      = rqm_q;
        tout_d     = tout_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (accept) begin
                    wr_d    = REQ_WR;
                    a0_d    = REQ_A0;
                    data_d  = REQ_DATA;
                    poll_d  = 16'd0;
                    tout_d  = 1'b0;
                    state_d = REQ_WAIT_RQM ? P_SETUP : D_SETUP;
                end
            end
            P_SETUP, D_SETUP: begin
                // The gap cycle (nCS high between a poll and the next access) does not count as setup.
                if (gap_q) begin
                    cnt_d = 8'd0;
                end else if (last) begin
                    cnt_d   = 8'd0;
                    state_d = (state_q == P_SETUP) ? P_STROBE : D_STROBE;
                end
            end
            P_STROBE: begin
                if (last) begin
                    rqm_d   = BUS_DI[7];
                    cnt_d   = 8'd0;
                    state_d = P_HOLD;
                end
            end
            P_HOLD: begin
                if (last) begin
                    cnt_d = 8'd0;
                    if (rqm_q) begin
                        gap_d   = 1'b1;
                        state_d = D_SETUP;
                    end else if (poll_q == 16'(POLL_LIMIT)) begin
                        tout_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        poll_d  = poll_q + 16'd1;
                        gap_d   = 1'b1;
                        state_d = P_SETUP;
                    end
                end
            end
            D_STROBE: begin
                if (last) begin
                    if (!wr_q) begin
                        rsp_data_d = BUS_DI;
                    end
                    cnt_d   = 8'd0;
                    state_d = D_HOLD;
                end
            end
            D_HOLD: begin
                if (last) begin
                    cnt_d   = 8'd0;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus pins are registered from the current state, so they trail the FSM by one cycle.
    always_comb begin
        in_poll     = (state_q == P_SETUP) || (state_q == P_STROBE) || (state_q == P_HOLD);
        in_data     = (state_q == D_SETUP) || (state_q == D_STROBE) || (state_q == D_HOLD);
        bus_ncs_d   = !((in_poll || in_data) && !gap_q);
        bus_nrd_d   = !((state_q == P_STROBE) || ((state_q == D_STROBE) && !wr_q));
        bus_nwr_d   = !((state_q == D_STROBE) && wr_q);
        bus_a0_d    = in_poll ? 1'b1 : (in_data ? a0_q : bus_a0_q);
        bus_do_d    = (in_data && wr_q) ? data_q : bus_do_q;
        rsp_valid_d = (state_q == RESP);
        rsp_tout_d  = (state_q == RESP) && tout_q;
        ready_d     = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            poll_q      <= 16'd0;
            gap_q       <= 1'b0;
            wr_q        <= 1'b0;
            a0_q        <= 1'b0;
            data_q      <= 8'h00;
            rqm_q       <= 1'b0;
            tout_q      <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_tout_q  <= 1'b0;
            bus_do_q    <= 8'h00;
            bus_a0_q    <= 1'b0;
            bus_ncs_q   <= 1'b1;
            bus_nrd_q   <= 1'b1;
            bus_nwr_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            poll_q      <= poll_d;
            gap_q       <= gap_d;
            wr_q        <= wr_d;
            a0_q        <= a0_d;
            data_q      <= data_d;
            rqm_q       <= rqm_d;
            tout_q      <= tout_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tout_q  <= rsp_tout_d;
            bus_do_q    <= bus_do_d;
            bus_a0_q    <= bus_a0_d;
            bus_ncs_q   <= bus_ncs_d;
            bus_nrd_q   <= bus_nrd_d;
            bus_nwr_q   <= bus_nwr_d;
        end
    end

    assign REQ_READY   = ready_q;
    assign BUSY        = busy_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_TIMEOUT = rsp_tout_q;
    assign BUS_DO      = bus_do_q;
    assign BUS_A0      = bus_a0_q;
    assign BUS_nCS     = bus_ncs_q;
    assign BUS_nRD     = bus_nrd_q;
    assign BUS_nWR     = bus_nwr_q;

endmodule

// File: tb/tb_upd_host_master.sv
// Bench for upd_host_master: DSP host-port model, per-cycle bus protocol monitor,
// directed vector table, back-to-back and reset-abort sequences, and randomized requests.
module tb_upd_host_master;

    localparam int SETUP  = 4;
    localparam int STROBE = 16;
    localparam int HOLD   = 4;
    localparam int PLIM   = 3;
    localparam int TXN    = SETUP + STROBE + HOLD;

    typedef struct {
        logic       wr;
        logic       a0;
        logic [7:0] data;
        logic       wait_rqm;
        int         ready_after;
        logic [7:0] sr_lo;
        logic [7:0] dr;
        logic       exp_tout;
        logic [7:0] exp_rsp;
        int         exp_nrd;
        int         exp_nwr;
        int         exp_nsr;
        int         exp_lat;
    } vec_t;

    logic       clk;
    logic       nRST;
    logic       REQ_VALID, REQ_READY, REQ_WR, REQ_A0, REQ_WAIT_RQM;
    logic [7:0] REQ_DATA;
    logic       RSP_VALID, RSP_TIMEOUT, BUSY;
    logic [7:0] RSP_DATA, BUS_DO, bus_di;
    logic       BUS_A0, BUS_nCS, BUS_nRD, BUS_nWR;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // DSP model state
    int         ready_after = 0;
    logic [7:0] sr_lo = 8'h00;
    logic [7:0] dr_val = 8'h00;
    int         sr_base = 0;
    int         sr_rises = 0;

    // monitor state
    int   nrd_falls = 0, nwr_falls = 0, sr_falls = 0, rsp_cnt = 0;
    int   ncs_fall = 0, ncs_rise = -1000, stb_fall = 0, stb_rise = 0, txn_start = 0;
    logic prev_ncs = 1'b1, prev_nrd = 1'b1, prev_nwr = 1'b1, prev_a0 = 1'b0, prev_rsp = 1'b0;
    logic [7:0] exp_do = 8'h00;

    vec_t tbl[8];

    upd_host_master #(.POLL_LIMIT(PLIM)) dut (
        .CLK(clk), .nRST(nRST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR), .REQ_A0(REQ_A0),
        .REQ_DATA(REQ_DATA), .REQ_WAIT_RQM(REQ_WAIT_RQM),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY),
        .BUS_DO(BUS_DO), .BUS_DI(bus_di), .BUS_A0(BUS_A0),
        .BUS_nCS(BUS_nCS), .BUS_nRD(BUS_nRD), .BUS_nWR(BUS_nWR)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // DSP host port: SR reports RQM after ready_after SR reads; junk when nRD is high.
    always_comb begin
        if (BUS_nRD)
            bus_di = 8'h66;
        else if (BUS_A0)
            bus_di = ((sr_rises - sr_base) < ready_after) ? {1'b0, sr_lo[6:0]} : {1'b1, sr_lo[6:0]};
        else
            bus_di = dr_val;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and run the bus protocol monitor.
    task automatic tick();
        logic stb_now, stb_prev;
        @(negedge clk);
        stb_now  = !(BUS_nRD && BUS_nWR);
        stb_prev = !(prev_nrd && prev_nwr);
        if (nRST) begin
            if (RSP_VALID) begin
                rsp_cnt++;
                chk("rsp_one_cycle", int'(prev_rsp), 0);
            end
            if (stb_now) chk("rd_wr_exclusive", int'(!BUS_nRD && !BUS_nWR), 0);
            if (stb_now != stb_prev) chk("strobe_vs_cs_a0", int'(BUS_nCS != prev_ncs || BUS_A0 != prev_a0), 0);
            if (!BUS_nCS && prev_ncs) begin
                if (ncs_rise > txn_start) chk("cs_gap", cyc - ncs_rise, 1);
                ncs_fall = cyc;
            end
            if (BUS_nCS && !prev_ncs) begin
                chk("cs_low_len", cyc - ncs_fall, TXN);
                chk("hold_len", cyc - stb_rise, HOLD);
                ncs_rise = cyc;
            end
            if (stb_now && !stb_prev) begin
                chk("setup_len", cyc - ncs_fall, SETUP);
                stb_fall = cyc;
                if (!BUS_nRD) begin
                    nrd_falls++;
                    if (BUS_A0) sr_falls++;
                end else begin
                    nwr_falls++;
                end
            end
            if (!stb_now && stb_prev) begin
                chk("strobe_len", cyc - stb_fall, STROBE);
                stb_rise = cyc;
                if (prev_a0 && !prev_nrd) sr_rises++;
            end
            if (!BUS_nWR) chk("bus_do", int'(BUS_DO), int'(exp_do));
        end
        prev_ncs = BUS_nCS;
        prev_nrd = BUS_nRD;
        prev_nwr = BUS_nWR;
        prev_a0  = BUS_A0;
        prev_rsp = RSP_VALID;
    endtask

    // Reference model: outcome of one request from the host-port rules.
    function automatic vec_t model(input vec_t v, input logic [7:0] prev_rsp_data);
        vec_t r;
        int polls;
        logic tout;
        r = v;
        if (!v.wait_rqm) begin
            polls = 0;
            tout  = 1'b0;
        end else if (v.ready_after <= PLIM) begin
            polls = v.ready_after + 1;
            tout  = 1'b0;
        end else begin
            polls = PLIM + 1;
            tout  = 1'b1;
        end
        r.exp_tout = tout;
        r.exp_nwr  = (!tout && v.wr) ? 1 : 0;
        r.exp_nrd  = polls + ((!tout && !v.wr) ? 1 : 0);
        r.exp_nsr  = polls + ((!tout && !v.wr && v.a0) ? 1 : 0);
        r.exp_lat  = tout ? polls * (TXN + 1) : polls * (TXN + 1) + TXN + 1;
        if (!tout && !v.wr)
            r.exp_rsp = v.a0 ? {logic'(polls >= v.ready_after), v.sr_lo[6:0]} : v.dr;
        else
            r.exp_rsp = prev_rsp_data;
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int n, acc, b_rd, b_wr, b_sr;
        ready_after = v.ready_after;
        sr_lo       = v.sr_lo;
        dr_val      = v.dr;
        sr_base     = sr_rises;
        exp_do      = v.data;
        REQ_WR       = v.wr;
        REQ_A0       = v.a0;
        REQ_DATA     = v.data;
        REQ_WAIT_RQM = v.wait_rqm;
        REQ_VALID    = 1'b1;
        n = 0;
        while (!REQ_READY && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_accept"}, int'(REQ_READY), 1);
        if (!REQ_READY) begin
            REQ_VALID = 1'b0;
            return;
        end
        acc       = cyc + 1;
        txn_start = acc;
        b_rd = nrd_falls;
        b_wr = nwr_falls;
        b_sr = sr_falls;
        tick();
        REQ_VALID    = 1'b0;
        REQ_WR       = 1'($urandom_range(0, 1));
        REQ_A0       = 1'($urandom_range(0, 1));
        REQ_DATA     = 8'($urandom_range(0, 255));
        REQ_WAIT_RQM = 1'($urandom_range(0, 1));
        chk({tag, "_busy"}, int'(BUSY), 1);
        chk({tag, "_ready_low"}, int'(REQ_READY), 0);
        n = 0;
        while (!RSP_VALID && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_seen"}, int'(RSP_VALID), 1);
        if (!RSP_VALID) return;
        chk({tag, "_latency"}, cyc - acc, v.exp_lat);
        chk({tag, "_rsp_data"}, int'(RSP_DATA), int'(v.exp_rsp));
        chk({tag, "_timeout"}, int'(RSP_TIMEOUT), int'(v.exp_tout));
        chk({tag, "_nrd_cnt"}, nrd_falls - b_rd, v.exp_nrd);
        chk({tag, "_nwr_cnt"}, nwr_falls - b_wr, v.exp_nwr);
        chk({tag, "_sr_reads"}, sr_falls - b_sr, v.exp_nsr);
        chk({tag, "_busy_end"}, int'(BUSY), 0);
        chk({tag, "_ready_end"}, int'(REQ_READY), 1);
    endtask

    task automatic back_to_back(input logic [7:0] hold_rsp);
        int n, acc, prev_rsp_cyc, b_wr;
        REQ_WR = 1'b1;
        REQ_A0 = 1'b0;
        REQ_WAIT_RQM = 1'b0;
        REQ_DATA = 8'h10;
        REQ_VALID = 1'b1;
        prev_rsp_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!REQ_READY && n < 100) begin
                tick();
                n++;
            end
            chk("b2b_accept", int'(REQ_READY), 1);
            acc = cyc + 1;
            if (i > 0) chk("b2b_gap", acc, prev_rsp_cyc + 1);
            exp_do    = REQ_DATA;
            txn_start = acc;
            b_wr      = nwr_falls;
            tick();
            if (i < 5) REQ_DATA = 8'h10 + 8'(17 * (i + 1));
            else       REQ_VALID = 1'b0;
            n = 0;
            while (!RSP_VALID && n < 400) begin
                tick();
                n++;
            end
            chk("b2b_rsp_seen", int'(RSP_VALID), 1);
            prev_rsp_cyc = cyc;
            chk("b2b_latency", cyc - acc, TXN + 1);
            chk("b2b_nwr_cnt", nwr_falls - b_wr, 1);
            chk("b2b_rsp_data", int'(RSP_DATA), int'(hold_rsp));
        end
        REQ_VALID = 1'b0;
    endtask

    task automatic reset_abort();
        int n, base;
        vec_t v;
        REQ_WR = 1'b1;
        REQ_A0 = 1'b0;
        REQ_WAIT_RQM = 1'b0;
        REQ_DATA = 8'h5E;
        exp_do = 8'h5E;
        REQ_VALID = 1'b1;
        n = 0;
        while (!REQ_READY && n < 100) begin
            tick();
            n++;
        end
        txn_start = cyc + 1;
        tick();
        REQ_VALID = 1'b0;
        n = 0;
        while (BUS_nWR && n < 100) begin
            tick();
            n++;
        end
        chk("abort_nwr_low", int'(BUS_nWR), 0);
        repeat (3) tick();
        base = rsp_cnt;
        #2 nRST = 1'b0;
        #1;
        chk("abort_nwr_async", int'(BUS_nWR), 1);
        chk("abort_ncs_async", int'(BUS_nCS), 1);
        chk("abort_nrd_async", int'(BUS_nRD), 1);
        chk("abort_ready", int'(REQ_READY), 0);
        chk("abort_busy", int'(BUSY), 0);
        repeat (3) tick();
        nRST = 1'b1;
        tick();
        chk("abort_ready_after", int'(REQ_READY), 1);
        chk("abort_rsp_data", int'(RSP_DATA), 0);
        repeat (30) tick();
        chk("abort_no_rsp", rsp_cnt - base, 0);
        v = '{1'b1, 1'b0, 8'hA7, 1'b0, 0, 8'h00, 8'h00, 1'b0, 8'h00, 0, 0, 0, 0};
        run_txn(model(v, 8'h00), "post_reset");
    endtask

    initial begin
        vec_t v;
        logic [7:0] model_rsp;
        nRST = 1'b0;
        REQ_VALID = 1'b0;
        REQ_WR = 1'b0;
        REQ_A0 = 1'b0;
        REQ_DATA = 8'h00;
        REQ_WAIT_RQM = 1'b0;

        //            wr    a0    data   wait  ra  sr_lo  dr    | tout  rsp    nrd nwr nsr lat
        tbl[0] = '{1'b1, 1'b0, 8'h02, 1'b0, 0,  8'h00, 8'h00, 1'b0, 8'h00, 0, 1, 0, 25};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 0,  8'h00, 8'hA5, 1'b0, 8'hA5, 1, 0, 0, 25};
        tbl[2] = '{1'b1, 1'b0, 8'hC2, 1'b1, 3,  8'h00, 8'h00, 1'b0, 8'hA5, 4, 1, 4, 125};
        tbl[3] = '{1'b1, 1'b0, 8'h33, 1'b1, 99, 8'h00, 8'h00, 1'b1, 8'hA5, 4, 0, 4, 100};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 1'b0, 0,  8'h15, 8'h00, 1'b0, 8'h95, 1, 0, 1, 25};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1,  8'h00, 8'h3C, 1'b0, 8'h3C, 3, 0, 2, 75};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 99, 8'h00, 8'h77, 1'b1, 8'h3C, 4, 0, 4, 100};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 2,  8'h01, 8'h00, 1'b0, 8'h81, 4, 0, 4, 100};

        // reset values
        repeat (2) tick();
        chk("rst_ncs", int'(BUS_nCS), 1);
        chk("rst_nrd", int'(BUS_nRD), 1);
        chk("rst_nwr", int'(BUS_nWR), 1);
        chk("rst_a0", int'(BUS_A0), 0);
        chk("rst_do", int'(BUS_DO), 0);
        chk("rst_ready", int'(REQ_READY), 0);
        chk("rst_rsp_valid", int'(RSP_VALID), 0);
        chk("rst_rsp_data", int'(RSP_DATA), 0);
        chk("rst_timeout", int'(RSP_TIMEOUT), 0);
        chk("rst_busy", int'(BUSY), 0);
        nRST = 1'b1;
        tick();
        chk("ready_after_release", int'(REQ_READY), 1);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
            repeat (2) tick();
        end

        back_to_back(tbl[7].exp_rsp);
        repeat (3) tick();

        model_rsp = tbl[7].exp_rsp;
        for (int i = 0; i < 30; i++) begin
            v.wr          = 1'($urandom_range(0, 1));
            v.a0          = 1'($urandom_range(0, 1));
            v.data        = 8'($urandom_range(0, 255));
            v.wait_rqm    = 1'($urandom_range(0, 1));
            v.ready_after = $urandom_range(0, 5);
            v.sr_lo       = 8'($urandom_range(0, 255));
            v.dr          = 8'($urandom_range(0, 255));
            v = model(v, model_rsp);
            model_rsp = v.exp_rsp;
            run_txn(v, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 3)) tick();
        end

        reset_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/upd_host_master.md
Name: upd_host_master

Overview:
- Host-side bus initiator for the uPD77C25 DSP host port (DR/SR byte access via nCS/nRD/nWR/A0).
- Converts single-byte read/write requests from the SNES-side mapper logic into correctly timed host-port strobe cycles.
- Optionally polls SR.RQM before each data access, and returns read data or a completion/timeout status.
- Sits between the address decoder and the DSP core's DI/DO/A0/nCS/nRD/nWR pins.

Parameters:
- SETUP_CYC, 4: CLK cycles with nCS low and A0/data stable before the strobe falls (1..255).
- STROBE_CYC, 16: CLK cycles nRD/nWR held low (1..255).
- HOLD_CYC, 4: CLK cycles with nCS low and A0/data stable after the strobe rises (1..255).
- POLL_LIMIT, 4095: maximum SR poll reads before RSP_TIMEOUT (1..65535).

Ports:
- CLK, in, 1: sole clock.
- nRST, in, 1: asynchronous active-low reset.
- REQ_VALID, in, 1: request present.
- REQ_READY, out, 1: request accepted when both REQ_VALID and REQ_READY are high on a rising CLK.
- REQ_WR, in, 1: 1 = write, 0 = read.
- REQ_A0, in, 1: host-port A0 for the data access (0 = DR, 1 = SR).
- REQ_DATA, in, 8: write byte.
- REQ_WAIT_RQM, in, 1: poll SR bit 7 (RQM) until set before the data access.
- RSP_VALID, out, 1: one-cycle completion pulse.
- RSP_DATA, out, 8: read byte. Holds its previous value after writes and timeouts.
- RSP_TIMEOUT, out, 1: valid with RSP_VALID; 1 = poll limit hit, data access skipped.
- BUSY, out, 1: high whenever the FSM is not in IDLE.
- BUS_DO, out, 8: to DSP DI.
- BUS_DI, in, 8: from DSP DO.
- BUS_A0, out, 1: to DSP A0.
- BUS_nCS, out, 1: to DSP nCS.
- BUS_nRD, out, 1: to DSP nRD.
- BUS_nWR, out, 1: to DSP nWR.

Behaviour:
- Reset (async, nRST=0):
  - BUS_nCS = BUS_nRD = BUS_nWR = 1; BUS_A0 = 0; BUS_DO = 0x00.
  - REQ_READY = 0 while in reset; 1 from the first CLK edge after release.
  - RSP_VALID = 0, RSP_DATA = 0x00, RSP_TIMEOUT = 0, BUSY = 0.
  - State goes to IDLE and all counters clear.
- All bus outputs are registered, so there are no glitches.
- REQ_READY = 1 only in IDLE. Accepting a request latches REQ_WR, REQ_A0, REQ_DATA and REQ_WAIT_RQM. Later input changes are ignored until the next accept.
- FSM states: IDLE, P_SETUP, P_STROBE, P_HOLD, D_SETUP, D_STROBE, D_HOLD, RESP.
- IDLE, on accept: go to P_SETUP if WAIT_RQM is set, else D_SETUP.
- Poll read cycle (P_SETUP / P_STROBE / P_HOLD):
  - BUS_A0 = 1, nCS low across all three states, nRD low only in P_STROBE.
  - BUS_DI is sampled on the last P_STROBE cycle, before nRD rises.
  - After P_HOLD, nCS goes high for exactly one cycle.
  - If the sampled bit 7 = 1: go to D_SETUP.
  - Else, if poll count == POLL_LIMIT: set the timeout flag and go to RESP.
  - Else: increment the poll count and go to P_SETUP.
- Data cycle (D_SETUP / D_STROBE / D_HOLD):
  - BUS_A0 = latched A0; nCS low across all three states.
  - Write: BUS_DO = latched data from D_SETUP through D_HOLD; nWR low only in D_STROBE.
  - Read: nRD low only in D_STROBE; BUS_DI is captured into RSP_DATA on the last D_STROBE cycle.
  - Then go to RESP.
- Durations: each SETUP state lasts SETUP_CYC, each STROBE state STROBE_CYC, each HOLD state HOLD_CYC cycles.
- nCS returns high on entry to RESP.
- nRD and nWR are never both low. A strobe never changes in the same cycle as nCS or A0.
- RESP lasts 1 cycle: RSP_VALID = 1 and RSP_TIMEOUT = flag; then IDLE.
- Latency, write with no polling, accepted at edge T: nCS falls at T+1, nWR falls at T+1+SETUP_CYC, RSP_VALID high at T+1+SETUP_CYC+STROBE_CYC+HOLD_CYC, next accept one cycle later.
  - Defaults: 24-cycle transaction plus 1 idle cycle.
- The poll counter is 16 bits and cleared on every accept. It never wraps, because POLL_LIMIT is at most 65535.
- BUS_DI is sampled only on the defined cycles; it is don't-care at all other times.
- Reset mid-transaction: strobes and nCS deassert immediately (asynchronously). No RSP_VALID is issued for the aborted request.

Test Plan:
- Defaults; write A0=0, data 0x02, WAIT_RQM=0 -> nCS low for 24 cycles; nWR low for exactly 16 cycles starting 4 cycles after nCS falls; BUS_DO=0x02 throughout; RSP_VALID 1 cycle, RSP_TIMEOUT=0.
- Read A0=0 with the DSP model presenting 0xA5 -> nRD pulse 16 cycles, RSP_DATA=0xA5, nWR stays high.
- WAIT_RQM=1; SR model returns 0x00, 0x00, 0x00, then 0x80; write 0xC2 -> exactly 4 poll read strobes with A0=1, one nCS-high cycle between them, then one data write with A0=0, BUS_DO=0xC2.
- POLL_LIMIT=3, SR stuck at 0x00 -> 4 poll strobes, no data strobe, RSP_VALID with RSP_TIMEOUT=1, RSP_DATA unchanged.
- Back-to-back: REQ_VALID held high with 6 queued writes -> each accepted exactly one cycle after the prior RSP_VALID; no overlapping strobes.
- nRST pulled low during D_STROBE of a write -> nWR and nCS go high with no clock edge; no RSP_VALID; after release REQ_READY=1 and the next request completes normally.
